binary_to_gray_counter: RTL and testbench

// - Loadable N-bit up/down counter. Presents its state as registered binary and registered Gray code.
// - Gray output is the encoding side of the gray_code_to_binary_convertor datapath.
// - Typical uses: async-FIFO pointers and clock-domain-crossing counts, where only one output bit
//   may change per step.
// - Sits on the source side of a CDC boundary; the sink side decodes with the Gray->binary converter.
//

---
 rtl/gray_pkg.sv | 24 ++
 rtl/bin2gray_encoder.sv | 25 ++
 rtl/binary_to_gray_counter.sv | 83 ++++++++
 tb/tb_binary_to_gray_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the binary->Gray counter and the Gray->binary converter.
// Both directions are defined here so the encoder and decoder cannot drift apart.
// The functions work on a fixed GRAY_MAX_N-bit container. Callers zero-extend narrower
// values and truncate the result; zero high bits do not disturb the low bits.
package gray_pkg;

  localparam int unsigned GRAY_MIN_N = 2;
  localparam int unsigned GRAY_MAX_N = 32;

  function automatic logic [GRAY_MAX_N-1:0] bin2gray(input logic [GRAY_MAX_N-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [GRAY_MAX_N-1:0] gray2bin(input logic [GRAY_MAX_N-1:0] gray);
    logic [GRAY_MAX_N-1:0] bin;
    bin[GRAY_MAX_N-1] = gray[GRAY_MAX_N-1];
    for (int i = GRAY_MAX_N - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin2gray_encoder.sv
// Purely combinational N-bit binary -> Gray encoder. Usable standalone.
// Ports:
//   bin   in  N  binary input
//   gray  out N  Gray code of bin
module bin2gray_encoder
  import gray_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  logic [GRAY_MAX_N-1:0] gray_wide;

  always_comb begin
    gray_wide = bin2gray(GRAY_MAX_N'(bin));
    gray      = gray_wide[N-1:0];
  end

  // Only the low N bits of gray_wide are meaningful; the rest are always zero.
  logic unused_gray_wide;
  assign unused_gray_wide = ^gray_wide;

endmodule

// File: rtl/binary_to_gray_counter.sv
// Loadable N-bit up/down counter with registered binary and Gray outputs and a registered
// wrap pulse. Both outputs are encoded from the same next-state value, so they update on the
// same edge, and Gray comes straight from a flop (no combinational path to the port), which
// keeps it safe to sample in another clock domain.
// Ports:
//   clk           in   1  clock, all state on posedge
//   rstn          in   1  asynchronous active-low reset
//   en            in   1  count enable, one step per cycle
//   up_dn         in   1  1 = increment, 0 = decrement
//   load          in   1  synchronous load strobe, wins over en
//   load_value    in   N  binary value captured on load
//   binary_value  out  N  registered binary count
//   gray_value    out  N  registered Gray code of binary_value
//   wrap          out  1  one-cycle pulse on a counting wrap (never on load)
module binary_to_gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] binary_value,
  output logic [N-1:0] gray_value,
  output logic         wrap
);

  if (N < GRAY_MIN_N) begin : g_bad_min_n
    $error("binary_to_gray_counter: N must be >= %0d", GRAY_MIN_N);
  end
  if (N > GRAY_MAX_N) begin : g_bad_max_n
    $error("binary_to_gray_counter: N must be <= %0d", GRAY_MAX_N);
  end

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;

  // Next-state: load > count > hold. Wrap is decided from the current count, before the
  // modulo arithmetic throws away the carry/borrow.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_value;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + N'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - N'(1);
        wrap_d = ~|bin_q;
      end
    end
  end

  bin2gray_encoder #(
    .N (N)
  ) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign binary_value = bin_q;
  assign gray_value   = gray_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
module tb_binary_to_gray_counter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] binary_value;
  logic [N-1:0] gray_value;
  logic         wrap;

  int n_cmp;
  int n_bad;

  binary_to_gray_counter #(
    .N (N)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .up_dn        (up_dn),
    .load         (load),
    .load_value   (load_value),
    .binary_value (binary_value),
    .gray_value   (gray_value),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [N-1:0] lv;
    logic         en;
    logic         up;
    logic [N-1:0] eb;
    logic [N-1:0] eg;
    logic         ew;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [N-1:0] lv, input logic e, input logic u,
                     input logic [N-1:0] eb, input logic [N-1:0] eg, input logic ew);
    vec_t v;
    v.load = ld; v.lv = lv; v.en = e; v.up = u; v.eb = eb; v.eg = eg; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] eb, input logic [N-1:0] eg,
                           input logic ew);
    check({tag, ".bin"},  32'(binary_value), 32'(eb));
    check({tag, ".gray"}, 32'(gray_value),   32'(eg));
    check({tag, ".wrap"}, 32'(wrap),         32'(ew));
  endtask

  // Drive inputs, let one posedge happen, then sample 1 time unit later.
  task automatic step(input logic ld, input logic [N-1:0] lv, input logic e, input logic u);
    load = ld; load_value = lv; en = e; up_dn = u;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] decode(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    logic [N-1:0] up_gray [16];
    logic [N-1:0] prev_gray;
    logic [N-1:0] m_bin;
    logic         m_wrap;
    logic         r_ld, r_en, r_up;
    logic [N-1:0] r_lv;

    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_value = '0;

    // Gray codes of 1..15, then 0 on the wrap step.
    up_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    for (int i = 0; i < 16; i++) add(1'b0, 4'h0, 1'b1, 1'b1, 4'(i + 1), up_gray[i], i == 15);
    // Down from 0: wrap to F, then E.
    add(1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 4'h8, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 4'h9, 1'b0);
    // Back up to F, then load beats en at F.
    add(1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h8, 1'b0);
    add(1'b1, 4'h5, 1'b1, 1'b1, 4'h5, 4'h7, 1'b0);
    // Load of the wrapped value from F must not pulse wrap.
    add(1'b1, 4'hF, 1'b0, 1'b0, 4'hF, 4'h8, 1'b0);
    add(1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    // Hold at 6 for three cycles, then flip direction every cycle.
    add(1'b1, 4'h6, 1'b0, 1'b0, 4'h6, 4'h5, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 4'h6, 4'h5, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 4'h6, 4'h5, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 4'h6, 4'h5, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 4'h4, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b0, 4'h6, 4'h5, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 4'h4, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b0, 4'h6, 4'h5, 1'b0);

    // Reset state, then release away from a clock edge.
    #12;
    check_all("reset", 4'h0, 4'h0, 1'b0);
    rstn = 1'b1;

    prev_gray = gray_value;
    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up);
      check_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].eg, vecs[i].ew);
      if (!vecs[i].load && vecs[i].en)
        check($sformatf("vec%0d.onebit", i), 32'($countones(gray_value ^ prev_gray)), 32'd1);
      prev_gray = gray_value;
    end

    // Asynchronous reset mid-count at 9: outputs clear before any edge and hold while low.
    step(1'b1, 4'h9, 1'b0, 1'b0);
    check_all("load9", 4'h9, 4'hD, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rst_hold", 4'h0, 4'h0, 1'b0);
    #2;
    rstn = 1'b1;
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check_all("rst_resume", 4'h1, 4'h1, 1'b0);

    // A live wrap pulse is also cleared asynchronously.
    step(1'b1, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check_all("wrap_pre", 4'h0, 4'h0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_all("wrap_rst", 4'h0, 4'h0, 1'b0);
    #2;
    rstn = 1'b1;

    // Random traffic against an independent model, with a Gray->binary round trip.
    m_bin = '0;
    prev_gray = gray_value;
    for (int i = 0; i < 200; i++) begin
      r_ld = ($urandom_range(7) == 0);
      r_lv = 4'($urandom_range(15));
      r_en = ($urandom_range(3) != 0);
      r_up = 1'($urandom_range(1));
      m_wrap = 1'b0;
      if (r_ld) m_bin = r_lv;
      else if (r_en) begin
        m_wrap = r_up ? (m_bin == 4'hF) : (m_bin == 4'h0);
        m_bin  = r_up ? 4'(m_bin + 1) : 4'(m_bin - 1);
      end
      step(r_ld, r_lv, r_en, r_up);
      check_all($sformatf("rnd%0d", i), m_bin, m_bin ^ (m_bin >> 1), m_wrap);
      check($sformatf("rnd%0d.decode", i), 32'(decode(gray_value)), 32'(m_bin));
      if (!r_ld && r_en)
        check($sformatf("rnd%0d.onebit", i), 32'($countones(gray_value ^ prev_gray)), 32'd1);
      prev_gray = gray_value;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
